// File: rtl/breath_pwm_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : breath_pwm_meter_pkg
// Description : Shared types and widths for the breathing-light PWM pair.
// Revision    : 1.0 - initial release
// ============================================================================
package breath_pwm_meter_pkg;

    // Common counter width so generator and meter agree on range.
    localparam int DEFAULT_CNT_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/breath_pwm_meter_pwm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sync_edge
// Description : Two-flop synchronizer plus delay flop; flags entry to ON_LEVEL.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_sync_edge #(
    parameter logic ON_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic start
);

    logic s1_q, s2_q, s3_q;

    // Idle level is the "off" level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= ~ON_LEVEL;
            s2_q <= ~ON_LEVEL;
            s3_q <= ~ON_LEVEL;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign start = (s2_q == ON_LEVEL) && (s3_q != ON_LEVEL);

endmodule
`default_nettype wire

// File: rtl/breath_pwm_meter.sv
`default_nettype none
// ============================================================================
// Module      : breath_pwm_meter
// Description : Measures on-time and period of an external PWM line; flags stuck.
// Revision    : 1.0 - initial release
// ============================================================================
module breath_pwm_meter
    import breath_pwm_meter_pkg::*;
#(
    parameter int          CNT_W    = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT  = 24000000,
    parameter logic        ON_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] on_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic             w_level;
    logic             w_start;
    logic [CNT_W-1:0] w_on_inc;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] o_q, o_d;
    logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             stuck_level_q, stuck_level_d;

    pwm_sync_edge #(
        .ON_LEVEL (ON_LEVEL)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (w_level),
        .start  (w_start)
    );

    assign w_on_inc = {{(CNT_W-1){1'b0}}, (w_level == ON_LEVEL)};

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        o_d           = o_q;
        on_cnt_d      = on_cnt_q;
        period_cnt_d  = period_cnt_q;
        valid_d       = 1'b0;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;
        case (state_q)
            ST_IDLE: begin
                // First period after reset is partial and never reported.
                if (w_start) begin
                    state_d = ST_MEASURE;
                    p_d     = C_ONE;
                    o_d     = C_ONE;
                end
            end
            ST_MEASURE: begin
                // Start edge wins over timeout so a period of exactly TIMEOUT reports.
                if (w_start) begin
                    period_cnt_d = p_q;
                    on_cnt_d     = o_q;
                    valid_d      = 1'b1;
                    p_d          = C_ONE;
                    o_d          = C_ONE;
                end else if (p_q == C_TIMEOUT) begin
                    state_d       = ST_STUCK;
                    stuck_d       = 1'b1;
                    stuck_level_d = w_level;
                    on_cnt_d      = '0;
                    period_cnt_d  = '0;
                end else begin
                    p_d = p_q + C_ONE;
                    o_d = o_q + w_on_inc;
                end
            end
            ST_STUCK: begin
                if (w_start) begin
                    state_d = ST_MEASURE;
                    stuck_d = 1'b0;
                    p_d     = C_ONE;
                    o_d     = C_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            p_q           <= '0;
            o_q           <= '0;
            on_cnt_q      <= '0;
            period_cnt_q  <= '0;
            valid_q       <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= ~ON_LEVEL;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            o_q           <= o_d;
            on_cnt_q      <= on_cnt_d;
            period_cnt_q  <= period_cnt_d;
            valid_q       <= valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign on_cnt      = on_cnt_q;
    assign period_cnt  = period_cnt_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule
`default_nettype wire

// File: tb/tb_breath_pwm_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_breath_pwm_meter
// Description : Scoreboard bench for breath_pwm_meter (CNT_W=8, TIMEOUT=50).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_breath_pwm_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 50;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             pwm_in = 1'b1;
    logic [CNT_W-1:0] on_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             valid;
    logic             stuck;
    logic             stuck_level;

    breath_pwm_meter #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .ON_LEVEL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .on_cnt      (on_cnt),
        .period_cnt  (period_cnt),
        .valid       (valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int on;
        int per;
        int at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   armed  = 0;
    int   prev_n = 0;
    int   prev_k = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected report.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got on=%0d period=%0d at cycle %0d, expected no valid",
                         on_cnt, period_cnt, cyc);
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.at);
                chk("period_cnt", int'(period_cnt), e.per);
                chk("on_cnt", int'(on_cnt), e.on);
                chk("on_le_period", int'(on_cnt <= period_cnt), 1);
            end
        end
    end

    // One PWM period: low for k cycles, high for the rest; cut < n truncates it.
    task automatic pwm_period(input int n, input int k, input int cut);
        bit exp_st;
        if (armed != 0 && prev_n <= TIMEOUT)
            sb.push_back('{on: prev_k, per: prev_n, at: cyc + 3});
        armed = 1;
        for (int i = 0; i < cut; i++) begin
            pwm_in = (i < k) ? 1'b0 : 1'b1;
            @(negedge clk);
            // i+1 rising edges have passed since this period's falling edge was driven.
            if (i + 1 < 3)
                exp_st = (prev_n > TIMEOUT) && (prev_n + i + 1 >= TIMEOUT + 3);
            else
                exp_st = (n > TIMEOUT) && (i + 1 >= TIMEOUT + 3);
            chk("stuck", int'(stuck), int'(exp_st));
            if (exp_st) begin
                chk("stuck_level", int'(stuck_level), 1);
                chk("stuck_on_cnt", int'(on_cnt), 0);
                chk("stuck_period_cnt", int'(period_cnt), 0);
            end
        end
        prev_n = n;
        prev_k = k;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_on_cnt"}, int'(on_cnt), 0);
        chk({tag, "_period_cnt"}, int'(period_cnt), 0);
        chk({tag, "_stuck"}, int'(stuck), 0);
        chk({tag, "_stuck_level"}, int'(stuck_level), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset held while the line toggles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pwm_in = ~pwm_in;
        end
        pwm_in = 1'b1;
        @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Steady PWM, period 20, low 5.
        repeat (4) pwm_period(20, 5, 20);

        // Duty sweep at period 20.
        for (int k = 2; k <= 18; k += 4) pwm_period(20, k, 20);

        // Boundaries: exactly TIMEOUT reports, TIMEOUT+1 goes stuck.
        pwm_period(TIMEOUT, 5, TIMEOUT);
        pwm_period(TIMEOUT + 1, 5, TIMEOUT + 1);
        repeat (2) pwm_period(20, 5, 20);

        // Line stops high, then resumes.
        pwm_period(150, 5, 150);
        repeat (3) pwm_period(20, 5, 20);

        // Reset 10 cycles into a period.
        pwm_period(20, 5, 10);
        rst_n = 1'b0;
        #1;
        check_cleared("midreset");
        armed  = 0;
        prev_n = 0;
        chk("midreset_sb_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        repeat (3) pwm_period(20, 7, 20);

        // Flush the last complete period.
        pwm_period(20, 5, 8);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
